// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges stall requests, sequences
// exception/eret flushes with a PC redirect, and runs a sticky stall watchdog.
module pipeline_ctrl #(
    parameter int unsigned FLUSH_CYCLES  = 1,
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
    parameter int unsigned STALL_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        excp_valid,
    input  logic        excp_is_eret,
    input  logic [31:0] epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        busy,
    output logic        stall_timeout
);

    typedef enum logic [1:0] {ST_RUN, ST_PEND, ST_FLUSH} state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);
    localparam logic [9:0] WD_LIMIT   = 10'(STALL_TIMEOUT);

    state_t      state_q, state_d;
    logic [3:0]  fcnt_q, fcnt_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic [9:0]  wd_cnt_q, wd_cnt_d;
    logic        timeout_q, timeout_d;
    logic [5:0]  stall_req;

    // Highest requesting stage wins; it also holds everything upstream of it.
    always_comb begin
        stall_req = 6'b000000;
        if (stallreq_mem)
            stall_req = 6'b011111;
        else if (stallreq_ex)
            stall_req = 6'b001111;
        else if (stallreq_id)
            stall_req = 6'b000111;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= ST_RUN;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        new_pc_d = new_pc_q;
        case (state_q)
            ST_RUN: begin
                if (excp_valid) begin
                    new_pc_d = excp_is_eret ? epc_i : EXC_VECTOR;
                    // A memory transaction in flight must finish before flushing.
                    if (stallreq_mem) begin
                        state_d = ST_PEND;
                    end else begin
                        state_d = ST_FLUSH;
                        fcnt_d  = FLUSH_LOAD;
                    end
                end
            end
            ST_PEND: begin
                if (!stallreq_mem) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                fcnt_d = fcnt_q - 4'd1;
                if (fcnt_q <= 4'd1)
                    state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        stall = 6'b000000;
        flush = 1'b0;
        busy  = 1'b0;
        case (state_q)
            ST_RUN:   stall = stall_req;
            ST_PEND: begin
                stall = stall_req;
                busy  = 1'b1;
            end
            ST_FLUSH: begin
                flush = 1'b1;
                busy  = 1'b1;
            end
            default: ;
        endcase
        if (!rst)
            stall = 6'b000000;
    end

    // Watchdog saturates at the limit so it can never wrap back under it.
    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q;
        if (stall == 6'b000000)
            wd_cnt_d = 10'd0;
        else if (wd_cnt_q < WD_LIMIT)
            wd_cnt_d = wd_cnt_q + 10'd1;
        if (wd_cnt_d >= WD_LIMIT)
            timeout_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fcnt_q    <= 4'd0;
            new_pc_q  <= 32'h0;
            wd_cnt_q  <= 10'd0;
            timeout_q <= 1'b0;
        end else begin
            fcnt_q    <= fcnt_d;
            new_pc_q  <= new_pc_d;
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign new_pc        = new_pc_q;
    assign stall_timeout = timeout_q;

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Merges per-stage stall requests into the per-stage hold vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb. Accepts exception/eret requests from the MEM stage and drives a timed pipeline flush plus a PC redirect. Runs a stall watchdog.

Parameters:
FLUSH_CYCLES, 1, number of cycles flush stays asserted per accepted exception (1..15)
EXC_VECTOR, 32'h0000_0020, redirect PC for a non-eret exception
STALL_TIMEOUT, 1023, consecutive stalled cycles before stall_timeout sets (counter width 10)

Ports:
clk  in  1  pipeline clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
stallreq_id  in  1  ID stage needs to hold (load-use hazard)
stallreq_ex  in  1  EX stage busy (multi-cycle mult/div)
stallreq_mem  in  1  MEM stage waiting on memory; transaction must not be aborted
excp_valid  in  1  MEM stage reports exception or eret this cycle
excp_is_eret  in  1  qualifies excp_valid: 1 = eret
epc_i  in  32  return PC for eret
stall  out  6  hold vector: bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb, bit5 wb
flush  out  1  clear all pipeline registers to NOP values
new_pc  out  32  redirect target, valid while flush=1
busy  out  1  FSM not in RUN
stall_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (rst=0, async): state RUN, stall=6'b000000, flush=0, new_pc=32'h0, busy=0, stall_timeout=0, pending exception cleared, counters 0.
- stall is combinational from requests and state. In RUN: stallreq_mem -> 6'b011111; else stallreq_ex -> 6'b001111; else stallreq_id -> 6'b000111; else 6'b000000. Highest stage wins.
- States: RUN, PEND, FLUSH.
- RUN, excp_valid=1, stallreq_mem=0: latch target (excp_is_eret ? epc_i : EXC_VECTOR) into new_pc, load flush counter with FLUSH_CYCLES, go to FLUSH next edge.
- RUN, excp_valid=1, stallreq_mem=1: latch target, go to PEND. stall=6'b011111 continues.
- PEND: stall follows the RUN priority rules. Go to FLUSH on the first edge where stallreq_mem=0. Further excp_valid is ignored; first exception wins.
- FLUSH: flush=1, stall=6'b000000, all stall requests ignored. Counter decrements each cycle. Leave for RUN on the edge where the counter reaches 1. flush is therefore high for exactly FLUSH_CYCLES cycles, starting the cycle after acceptance.
- new_pc holds its value until the next accepted exception. It is not cleared on leaving FLUSH.
- busy=1 in PEND and FLUSH.
- Exception in the same cycle as any stall request: exception acceptance takes priority over stallreq_id/ex, never over stallreq_mem.
- Watchdog: counter increments each cycle stall!=0 and clears when stall==0. When the count reaches STALL_TIMEOUT, stall_timeout sets and stays set until reset. Counter saturates and does not wrap.
- Reset during PEND or FLUSH aborts immediately to RUN. The pending target is discarded.

Test Plan:
- Priority: stallreq_id=1, then id+ex, then id+ex+mem, one cycle each -> stall = 6'b000111, 6'b001111, 6'b011111; all low -> 6'b000000.
- Exception in RUN: excp_valid=1, eret=0 -> next cycle flush=1, new_pc=32'h20, stall=0, busy=1. Following cycle flush=0, busy=0 (FLUSH_CYCLES=1).
- Eret during mem stall: stallreq_mem=1 for 3 cycles, excp_valid+eret with epc_i=32'h0000_1234 on cycle 1 -> PEND, stall=6'b011111 for 3 cycles, flush=1 on the cycle after stallreq_mem drops, new_pc=32'h1234.
- FLUSH_CYCLES=3: stallreq_ex=1 held during the flush -> flush high exactly 3 cycles with stall=0, then stall=6'b001111.
- Watchdog at STALL_TIMEOUT=4: stallreq_id held 4 cycles -> stall_timeout=1 after the 4th, and stays 1 after the request drops.
- Async reset mid-FLUSH: drive rst low between edges -> flush, busy, stall go 0 immediately with no clock. After release, an idle cycle shows state RUN.
